// File: rtl/mesm6_mem_arbiter_if.sv
// mesm6_mem_arbiter_if: core ibus/dbus and memory-controller signals shared by the arbiter
// Ports: ibus_* (fetch request/result), dbus_* (read/write request/result),
//        mem_* (single-ported memory handshake), arb_err (sticky fault flag).
// Modports: slave = the arbiter, master = the core/memory side driving it.
interface mesm6_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 48
);
  logic                  ibus_fetch;
  logic [ADDR_WIDTH-1:0] ibus_addr;
  logic [DATA_WIDTH-1:0] ibus_input;
  logic                  ibus_done;
  logic                  dbus_read;
  logic                  dbus_write;
  logic [ADDR_WIDTH-1:0] dbus_addr;
  logic [DATA_WIDTH-1:0] dbus_output;
  logic [DATA_WIDTH-1:0] dbus_input;
  logic                  dbus_done;
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ack;
  logic                  arb_err;
  modport slave (
    input  ibus_fetch, ibus_addr, dbus_read, dbus_write, dbus_addr, dbus_output, mem_rdata, mem_ack,
    output ibus_input, ibus_done, dbus_input, dbus_done, mem_req, mem_we, mem_addr, mem_wdata, arb_err
  );
  modport master (
    output ibus_fetch, ibus_addr, dbus_read, dbus_write, dbus_addr, dbus_output, mem_rdata, mem_ack,
    input  ibus_input, ibus_done, dbus_input, dbus_done, mem_req, mem_we, mem_addr, mem_wdata, arb_err
  );
endinterface

// File: rtl/mesm6_mem_arbiter.sv
// mesm6_mem_arbiter: shares one single-ported memory between the MESM-6 fetch bus and data bus
// Ports: clk (rising edge), reset (async, active-high), bus (mesm6_mem_arbiter_if.slave):
//        ibus fetch request -> ibus_input/ibus_done, dbus read/write -> dbus_input/dbus_done,
//        mem_req/we/addr/wdata out with mem_rdata/mem_ack back, sticky arb_err.
// TIMEOUT: cycles to wait for mem_ack before aborting (0 disables).
// Define MESM6_ARB_ROUND_ROBIN_EN to alternate grants on a tie; default is dbus-first priority.
module mesm6_mem_arbiter #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 48,
  parameter int TIMEOUT    = 255
) (
  input logic clk,
  input logic reset,
  mesm6_mem_arbiter_if.slave bus
);
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [1:0] IDLE = 2'd0, IBUS = 2'd1, DBUS = 2'd2, DONE = 2'd3;
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);

  logic [1:0]            state_q, state_d;
  logic                  mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH-1:0] ibus_input_q, ibus_input_d, dbus_input_q, dbus_input_d;
  logic                  ibus_done_q, ibus_done_d, dbus_done_q, dbus_done_d;
  logic                  arb_err_q, arb_err_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  d_req, i_req, d_gnt, tmo;
`ifdef MESM6_ARB_ROUND_ROBIN_EN
  logic                  last_grant_q, last_grant_d;
`endif

  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    ibus_input_d = ibus_input_q;
    dbus_input_d = dbus_input_q;
    ibus_done_d  = 1'b0;
    dbus_done_d  = 1'b0;
    arb_err_d    = arb_err_q;
    cnt_d        = cnt_q;
    d_req        = bus.dbus_read | bus.dbus_write;
    i_req        = bus.ibus_fetch;
`ifdef MESM6_ARB_ROUND_ROBIN_EN
    last_grant_d = last_grant_q;
    // last_grant 0 = ibus, so a tie goes to whichever bus was not served last
    d_gnt        = d_req & (~i_req | ~last_grant_q);
`else
    d_gnt        = d_req;
`endif
    // ack in the cycle the count would reach TIMEOUT wins over the abort
    tmo          = (TIMEOUT > 0) && !bus.mem_ack && (cnt_q == CNT_LAST);
    if (state_q == IDLE && (d_req | i_req)) begin
      state_d     = d_gnt ? DBUS : IBUS;
      mem_req_d   = 1'b1;
      mem_we_d    = d_gnt & bus.dbus_write;
      mem_addr_d  = d_gnt ? bus.dbus_addr : bus.ibus_addr;
      mem_wdata_d = bus.dbus_output;
      cnt_d       = '0;
      arb_err_d   = arb_err_q | (d_gnt & bus.dbus_read & bus.dbus_write);
`ifdef MESM6_ARB_ROUND_ROBIN_EN
      last_grant_d = d_gnt;
`endif
    end else if (state_q == IBUS || state_q == DBUS) begin
      if (bus.mem_ack || tmo) begin
        state_d     = DONE;
        mem_req_d   = 1'b0;
        ibus_done_d = state_q == IBUS;
        dbus_done_d = state_q == DBUS;
        arb_err_d   = arb_err_q | tmo;
        if (state_q == IBUS) ibus_input_d = tmo ? '0 : bus.mem_rdata;
        else if (tmo || !mem_we_q) dbus_input_d = tmo ? '0 : bus.mem_rdata;
      end else begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
      end
    end else if (state_q == DONE) begin
      // one dead cycle swallows the request level the core still holds after done
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      ibus_input_q <= '0;
      dbus_input_q <= '0;
      ibus_done_q  <= 1'b0;
      dbus_done_q  <= 1'b0;
      arb_err_q    <= 1'b0;
      cnt_q        <= '0;
`ifdef MESM6_ARB_ROUND_ROBIN_EN
      last_grant_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      ibus_input_q <= ibus_input_d;
      dbus_input_q <= dbus_input_d;
      ibus_done_q  <= ibus_done_d;
      dbus_done_q  <= dbus_done_d;
      arb_err_q    <= arb_err_d;
      cnt_q        <= cnt_d;
`ifdef MESM6_ARB_ROUND_ROBIN_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.ibus_input = ibus_input_q;
  assign bus.ibus_done  = ibus_done_q;
  assign bus.dbus_input = dbus_input_q;
  assign bus.dbus_done  = dbus_done_q;
  assign bus.arb_err    = arb_err_q;
endmodule

// File: tb/tb_mesm6_mem_arbiter.sv
// tb_mesm6_mem_arbiter: scoreboard bench; stimulus queues expected memory requests and done results
module tb_mesm6_mem_arbiter;
  typedef struct { bit we; logic [14:0] addr; logic [47:0] wdata; logic [47:0] rdata; int wt; } mem_t;
  typedef struct { bit d; logic [47:0] data; bit err; int lat; } done_t;

  logic clk = 0;
  logic reset = 1;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int req_cyc = 0;
  mem_t mq[$];
  done_t dq[$];

  mesm6_mem_arbiter_if #(.ADDR_WIDTH(15), .DATA_WIDTH(48)) bus ();
  mesm6_mem_arbiter #(.ADDR_WIDTH(15), .DATA_WIDTH(48), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", n, got, exp);
    end
  endtask

  task automatic exp_mem(input bit we, input logic [14:0] a, input logic [47:0] wd, input logic [47:0] rd, input int wt);
    mq.push_back('{we, a, wd, rd, wt});
  endtask

  task automatic exp_done(input bit d, input logic [47:0] data, input bit err, input int lat);
    dq.push_back('{d, data, err, lat});
  endtask

  task automatic wait_done(input bit d);
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = d ? bus.dbus_done : bus.ibus_done;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_done_timeout: no done within 40 cycles, expected one", d ? "dbus" : "ibus");
    end
  endtask

  task automatic xfer(input bit d, input bit rd, input bit wr, input logic [14:0] a, input logic [47:0] wd);
    @(posedge clk); #1;
    if (d) begin
      bus.dbus_read = rd; bus.dbus_write = wr; bus.dbus_addr = a; bus.dbus_output = wd;
    end else begin
      bus.ibus_fetch = 1; bus.ibus_addr = a;
    end
    req_cyc = cyc;
    wait_done(d);
    @(posedge clk); #1;
    bus.ibus_fetch = 0; bus.dbus_read = 0; bus.dbus_write = 0;
  endtask

  // memory model: pops one expected request per mem_req burst, checks it every cycle, acks after wt waits
  initial begin
    mem_t cur;
    bit act;
    int w;
    act = 0; w = 0;
    cur = '{0, 0, 0, 0, 0};
    bus.mem_ack = 0; bus.mem_rdata = 0;
    forever begin
      @(negedge clk);
      bus.mem_ack = 0;
      if (reset || !bus.mem_req) begin
        act = 0;
        continue;
      end
      if (!act) begin
        checks++;
        if (mq.size() == 0) begin
          errors++;
          $display("FAIL mem_unexpected: request at addr %h, expected none", bus.mem_addr);
          continue;
        end
        cur = mq.pop_front(); act = 1; w = 0;
      end
      chk("mem_we", bus.mem_we, cur.we);
      chk("mem_addr", bus.mem_addr, cur.addr);
      if (cur.we) chk("mem_wdata", bus.mem_wdata, cur.wdata);
      if (cur.wt >= 0 && w == cur.wt) begin
        bus.mem_ack = 1; bus.mem_rdata = cur.rdata; act = 0;
      end
      w++;
    end
  end

  // monitor: every done pulse is matched against the next expected completion
  initial begin
    done_t e;
    forever begin
      @(negedge clk);
      if (!reset && (bus.ibus_done || bus.dbus_done)) begin
        chk("done_exclusive", bus.ibus_done & bus.dbus_done, 0);
        if (dq.size() == 0) begin
          checks++; errors++;
          $display("FAIL done_unexpected: ibus_done=%b dbus_done=%b, expected none", bus.ibus_done, bus.dbus_done);
        end else begin
          e = dq.pop_front();
          chk("done_bus", bus.dbus_done, e.d);
          chk("done_data", e.d ? bus.dbus_input : bus.ibus_input, e.data);
          chk("done_err", bus.arb_err, e.err);
          if (e.lat >= 0) chk("done_latency", cyc - req_cyc, e.lat);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, expected completion");
    $fatal(1);
  end

  initial begin
    bus.ibus_fetch = 0; bus.ibus_addr = 0; bus.dbus_read = 0; bus.dbus_write = 0;
    bus.dbus_addr = 0; bus.dbus_output = 0;
    repeat (2) @(negedge clk);
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_done", {bus.ibus_done, bus.dbus_done}, 0);
    chk("rst_inputs", {bus.ibus_input, bus.dbus_input}, 0);
    chk("rst_err", bus.arb_err, 0);
    reset = 0;
    // single fetch, ack in first mem_req cycle, request held through DONE
    exp_mem(0, 15'h0010, 0, 48'h123456789ABC, 0);
    exp_done(0, 48'h123456789ABC, 0, 2);
    xfer(0, 0, 0, 15'h0010, 0);
    repeat (3) @(negedge clk);
    chk("fetch_no_retrigger", bus.mem_req, 0);
    // both requesters held: fixed priority D,D,I,I; round-robin D,I,D,I
`ifdef MESM6_ARB_ROUND_ROBIN_EN
    exp_mem(0, 15'h0100, 0, 48'hD1D1D1D1D1D1, 0); exp_done(1, 48'hD1D1D1D1D1D1, 0, -1);
    exp_mem(0, 15'h0200, 0, 48'h111111111111, 1); exp_done(0, 48'h111111111111, 0, -1);
    exp_mem(0, 15'h0100, 0, 48'hD2D2D2D2D2D2, 0); exp_done(1, 48'hD2D2D2D2D2D2, 0, -1);
    exp_mem(0, 15'h0200, 0, 48'h222222222222, 2); exp_done(0, 48'h222222222222, 0, -1);
`else
    exp_mem(0, 15'h0100, 0, 48'hD1D1D1D1D1D1, 0); exp_done(1, 48'hD1D1D1D1D1D1, 0, -1);
    exp_mem(0, 15'h0100, 0, 48'hD2D2D2D2D2D2, 0); exp_done(1, 48'hD2D2D2D2D2D2, 0, -1);
    exp_mem(0, 15'h0200, 0, 48'h111111111111, 1); exp_done(0, 48'h111111111111, 0, -1);
    exp_mem(0, 15'h0200, 0, 48'h222222222222, 2); exp_done(0, 48'h222222222222, 0, -1);
`endif
    @(posedge clk); #1;
    bus.dbus_read = 1; bus.dbus_addr = 15'h0100; bus.ibus_fetch = 1; bus.ibus_addr = 15'h0200;
    fork
      begin
        repeat (2) wait_done(1);
        @(posedge clk); #1; bus.dbus_read = 0;
      end
      begin
        repeat (2) wait_done(0);
        @(posedge clk); #1; bus.ibus_fetch = 0;
      end
    join
    // write with ack on the 4th mem_req cycle (same cycle the count would hit TIMEOUT)
    exp_mem(1, 15'h7FFF, 48'hFFFFFFFFFFFF, 48'h0123456789AB, 3);
    exp_done(1, 48'hD2D2D2D2D2D2, 0, 5);
    xfer(1, 0, 1, 15'h7FFF, 48'hFFFFFFFFFFFF);
    exp_mem(0, 15'h0123, 0, 48'h0BADC0FFEE00, 3);
    exp_done(1, 48'h0BADC0FFEE00, 0, 5);
    xfer(1, 1, 0, 15'h0123, 0);
    // no ack: abort after 4 cycles with zero data and error
    exp_mem(0, 15'h0300, 0, 0, -1);
    exp_done(1, 48'h0, 1, 5);
    xfer(1, 1, 0, 15'h0300, 0);
    chk("tmo_err_sticky", bus.arb_err, 1);
    // reset while a read waits on memory
    exp_mem(0, 15'h0400, 0, 0, -1);
    @(posedge clk); #1;
    bus.dbus_read = 1; bus.dbus_addr = 15'h0400;
    @(posedge clk);
    @(posedge clk); #2;
    chk("mid_mem_req", bus.mem_req, 1);
    reset = 1;
    #1;
    chk("async_mem_req", bus.mem_req, 0);
    chk("async_done", {bus.ibus_done, bus.dbus_done}, 0);
    chk("async_err", bus.arb_err, 0);
    bus.dbus_read = 0;
    repeat (2) @(negedge clk);
    reset = 0;
    chk("post_rst_inputs", {bus.ibus_input, bus.dbus_input}, 0);
    exp_mem(0, 15'h0020, 0, 48'h000000000042, 0);
    exp_done(0, 48'h000000000042, 0, 2);
    xfer(0, 0, 0, 15'h0020, 0);
    // read and write together: performed as a write, error sticks through good transfers
    exp_mem(1, 15'h0055, 48'hABCDEF012345, 48'h999999999999, 1);
    exp_done(1, 48'h0, 1, 3);
    xfer(1, 1, 1, 15'h0055, 48'hABCDEF012345);
    exp_mem(0, 15'h0030, 0, 48'h555555555555, 0);
    exp_done(0, 48'h555555555555, 1, 2);
    xfer(0, 0, 0, 15'h0030, 0);
    exp_mem(0, 15'h0031, 0, 48'h0AAAAAAAAAAA, 2);
    exp_done(1, 48'h0AAAAAAAAAAA, 1, 4);
    xfer(1, 1, 0, 15'h0031, 0);
    chk("fault_err_sticky", bus.arb_err, 1);
    @(posedge clk); #1;
    reset = 1;
    #1;
    chk("err_cleared_by_reset", bus.arb_err, 0);
    repeat (2) @(negedge clk);
    reset = 0;
    repeat (3) @(negedge clk);
    chk("mem_queue_empty", mq.size(), 0);
    chk("done_queue_empty", dq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
